// File: rtl/j_add32_nibser_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// nibble slice width and the derivation of the per-operation cycle count.
package j_add32_nibser_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of nibble cycles needed to cover an operand of the given width.
  function automatic int nibsFor(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/j_add32_nibser_add4.sv
// Four-bit ripple slice with carry in/out. One instance is reused every
// cycle by the nibble-serial adder.
module j_add4
  import j_add32_nibser_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_ci,
  output logic [NIB_W-1:0] o_s,
  output logic             o_co
);

  logic [NIB_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIB_W{1'b0}}, i_ci};
  assign o_s    = w_full[NIB_W-1:0];
  assign o_co   = w_full[NIB_W];

endmodule

// File: rtl/j_add32_nibser.sv
// Nibble-serial adder/subtractor. Operands are captured on accept, then one
// 4-bit slice is walked across them LS nibble first with the carry held in
// a flop. The full result and flags are registered only on the last nibble,
// so q/co/ov/z never expose partial sums.
module j_add32_nibser
  import j_add32_nibser_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             ci_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ov,
  output logic             z
);

  localparam int NIBS  = nibsFor(WIDTH);
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_rSh;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cy;
  logic             r_sub;
  logic             r_done;
  logic             r_co;
  logic             r_ov;
  logic             r_z;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [NIB_W-1:0] w_sum;
  logic             w_sliceCo;
  logic [WIDTH-1:0] w_result;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == CNT_LAST);
  assign w_result = {w_sum, r_rSh[WIDTH-1:NIB_W]};

  j_add4 u_slice (
    .i_a  (r_aSh[NIB_W-1:0]),
    .i_b  (r_bSh[NIB_W-1:0]),
    .i_ci (r_cy),
    .o_s  (w_sum),
    .o_co (w_sliceCo)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: leave IDLE on start, return once the last nibble is summed.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_nextState = ST_RUN;
      ST_RUN:  if (w_last) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Operand capture, nibble shifting and final result/flag registration.
  // Subtraction is a + ~b + ~borrow, so the carry-out is inverted to report
  // a borrow.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_aSh  <= '0;
      r_bSh  <= '0;
      r_rSh  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_cy   <= 1'b0;
      r_sub  <= 1'b0;
      r_done <= 1'b0;
      r_co   <= 1'b0;
      r_ov   <= 1'b0;
      r_z    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_aSh <= a;
        r_bSh <= sub ? ~b : b;
        r_cy  <= sub ? ~ci_in : ci_in;
        r_sub <= sub;
        r_cnt <= '0;
      end else if (w_run) begin
        r_cy  <= w_sliceCo;
        r_aSh <= {{NIB_W{1'b0}}, r_aSh[WIDTH-1:NIB_W]};
        r_bSh <= {{NIB_W{1'b0}}, r_bSh[WIDTH-1:NIB_W]};
        r_rSh <= w_result;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_q    <= w_result;
          r_co   <= r_sub ? ~w_sliceCo : w_sliceCo;
          r_ov   <= (r_aSh[NIB_W-1] & r_bSh[NIB_W-1] & ~w_sum[NIB_W-1]) |
                    (~r_aSh[NIB_W-1] & ~r_bSh[NIB_W-1] & w_sum[NIB_W-1]);
          r_z    <= (w_result == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = w_run;
  assign done = r_done;
  assign q    = r_q;
  assign co   = r_co;
  assign ov   = r_ov;
  assign z    = r_z;

endmodule
